// File: rtl/rot_unit_param.sv
// Rotate / shift / mask-insert execution unit, XLEN = 32 or 64.
// Operand bit 0 is the MSB (big-endian numbering), so architectural bit i
// lives at vector index XLEN-1-i. There are three elastic register stages:
// S0 captures the operands, S1 rotates and builds the mask, S2 merges and
// computes CR0/CA, and S2 also drives the outputs.
module rot_unit_param #(
  parameter int XLEN           = 32,
  parameter int RS_ID_WIDTH    = 5,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int SH_W          = $clog2(XLEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic [RS_ID_WIDTH-1:0]    rs_id_in,
  input  logic [REG_ADDR_WIDTH-1:0] result_reg_addr_in,
  input  logic [XLEN-1:0]           op1,
  input  logic [SH_W:0]             op2,
  input  logic [XLEN-1:0]           target,
  input  logic                      so_in,
  input  logic [2:0]                mode,
  input  logic [SH_W-1:0]           mb,
  input  logic [SH_W-1:0]           me,
  input  logic                      alter_cr0,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [RS_ID_WIDTH-1:0]    rs_id_out,
  output logic [REG_ADDR_WIDTH-1:0] result_reg_addr_out,
  output logic [XLEN-1:0]           result,
  output logic [3:0]                cr0,
  output logic                      cr0_valid,
  output logic                      ca,
  output logic                      ca_valid
);

  typedef enum logic [2:0] {
    OP_RLM = 3'd0,
    OP_RLI = 3'd1,
    OP_SL  = 3'd2,
    OP_SRL = 3'd3,
    OP_SRA = 3'd4
  } op_e;

  localparam logic [SH_W-1:0] LAST = SH_W'(XLEN - 1);

  // Ones in architectural bits b..e; wraps around when b > e.
  function automatic logic [XLEN-1:0] gen_mask(input logic [SH_W-1:0] b,
                                               input logic [SH_W-1:0] e);
    logic [XLEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (b <= e) m[XLEN-1-i] = (i >= 32'(b)) && (i <= 32'(e));
      else        m[XLEN-1-i] = (i >= 32'(b)) || (i <= 32'(e));
    end
    return m;
  endfunction

  // Stage state
  logic                      s0_valid, s1_valid;
  logic [RS_ID_WIDTH-1:0]    s0_tag, s1_tag;
  logic [REG_ADDR_WIDTH-1:0] s0_addr, s1_addr;
  logic [XLEN-1:0]           s0_op1, s0_target, s1_target;
  logic [SH_W:0]             s0_op2;
  logic                      s0_so, s1_so, s0_alter, s1_alter;
  logic [SH_W-1:0]           s0_mb, s0_me;
  op_e                       s0_mode, s1_mode;
  logic [XLEN-1:0]           s1_rot, s1_mask;
  logic                      s1_big, s1_nz, s1_sign;

  logic adv0, adv1, adv2;
  op_e  in_kind;

  // Elastic advance chain; input_ready never looks at input_valid.
  assign adv2        = !output_valid || output_ready;
  assign adv1        = !s1_valid || adv2;
  assign adv0        = !s0_valid || adv1;
  assign input_ready = adv0;

  // Reserved mode encodings fold onto rotate-AND-mask.
  always_comb begin
    in_kind = OP_RLM;
    case (mode)
      3'd1:    in_kind = OP_RLI;
      3'd2:    in_kind = OP_SL;
      3'd3:    in_kind = OP_SRL;
      3'd4:    in_kind = OP_SRA;
      default: in_kind = OP_RLM;
    endcase
  end

  // S1 combinational: rotate amount, mask bounds, rotation.
  logic [SH_W-1:0]   n_lo, amt, m_b, m_e;
  logic [2*XLEN-1:0] dbl;
  logic [XLEN-1:0]   rot_c, mask_c;

  // Shifts are rotates with a derived mask; right shifts rotate by -n mod XLEN.
  always_comb begin
    n_lo = s0_op2[SH_W-1:0];
    amt  = n_lo;
    m_b  = s0_mb;
    m_e  = s0_me;
    case (s0_mode)
      OP_SL: begin
        m_b = '0;
        m_e = LAST - n_lo;
      end
      OP_SRL, OP_SRA: begin
        amt = SH_W'(0) - n_lo;
        m_b = n_lo;
        m_e = LAST;
      end
      default: ;
    endcase
    dbl    = {s0_op1, s0_op1} << amt;
    rot_c  = dbl[2*XLEN-1:XLEN];
    mask_c = gen_mask(m_b, m_e);
  end

  // S2 combinational: merge, CR0 and carry.
  logic [XLEN-1:0] fill, res_c;
  logic [3:0]      cr0_c;
  logic            ca_c;

  // Select the merge rule per operation and derive flags from the result.
  always_comb begin
    fill  = {XLEN{s1_sign}};
    res_c = s1_rot & s1_mask;
    case (s1_mode)
      OP_RLI:        res_c = (s1_rot & s1_mask) | (s1_target & ~s1_mask);
      OP_SL, OP_SRL: res_c = s1_big ? '0 : (s1_rot & s1_mask);
      OP_SRA:        res_c = s1_big ? fill : ((s1_rot & s1_mask) | (fill & ~s1_mask));
      default:       res_c = s1_rot & s1_mask;
    endcase
    ca_c  = (s1_mode == OP_SRA) && s1_sign &&
            (s1_big ? s1_nz : |(s1_rot & ~s1_mask));
    cr0_c = {res_c[XLEN-1], !res_c[XLEN-1] && (res_c != '0), res_c == '0, s1_so};
  end

  // Valid bits: reset beats flush, flush kills every stage including the
  // operation handshaking this cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s0_valid     <= 1'b0;
      s1_valid     <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      if (adv0) s0_valid     <= input_valid;
      if (adv1) s1_valid     <= s0_valid;
      if (adv2) output_valid <= s1_valid;
    end
  end

  // S0/S1 data registers; contents are only meaningful under their valid.
  always_ff @(posedge clk) begin
    if (adv0) begin
      s0_tag    <= rs_id_in;
      s0_addr   <= result_reg_addr_in;
      s0_op1    <= op1;
      s0_op2    <= op2;
      s0_target <= target;
      s0_so     <= so_in;
      s0_mode   <= in_kind;
      s0_mb     <= mb;
      s0_me     <= me;
      s0_alter  <= alter_cr0;
    end
    if (adv1) begin
      s1_tag    <= s0_tag;
      s1_addr   <= s0_addr;
      s1_rot    <= rot_c;
      s1_mask   <= mask_c;
      s1_big    <= s0_op2[SH_W];
      s1_nz     <= |s0_op1;
      s1_sign   <= s0_op1[XLEN-1];
      s1_target <= s0_target;
      s1_so     <= s0_so;
      s1_alter  <= s0_alter;
      s1_mode   <= s0_mode;
    end
  end

  // Output stage registers; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      result              <= '0;
      cr0                 <= '0;
      ca                  <= 1'b0;
      cr0_valid           <= 1'b0;
      ca_valid            <= 1'b0;
      rs_id_out           <= '0;
      result_reg_addr_out <= '0;
    end else if (adv2) begin
      result              <= res_c;
      cr0                 <= cr0_c;
      ca                  <= ca_c;
      cr0_valid           <= s1_alter;
      ca_valid            <= (s1_mode == OP_SRA);
      rs_id_out           <= s1_tag;
      result_reg_addr_out <= s1_addr;
    end
  end

endmodule
